// File: rtl/uart_acia_if.sv
// CPU-side bus of the ACIA: decoder strobes, data buses and the interrupt line.
interface uart_acia_if;
    logic       uart_cs;
    logic       uart_rs;
    logic       uart_rd;
    logic       uart_we;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq_n;

    modport master (
        output uart_cs, uart_rs, uart_rd, uart_we, din,
        input  dout, irq_n
    );

    modport slave (
        input  uart_cs, uart_rs, uart_rd, uart_we, din,
        output dout, irq_n
    );
endinterface

// File: rtl/uart_acia.sv
// 6850-style ACIA: control/status and data registers on the CPU bus, fixed 8N1
// transmitter and receiver on txd/rxd, active-low interrupt.
module uart_acia #(
    parameter int unsigned CLK_DIV = 104
) (
    input  logic       cpu_clk,
    input  logic       rst,
    uart_acia_if.slave bus,
    input  logic       rxd,
    output logic       txd
);

    localparam logic [15:0] DivM1   = 16'(CLK_DIV - 1);
    localparam logic [15:0] DivHalf = 16'(CLK_DIV / 2);

    typedef enum logic {TxIdle, TxShift} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    logic [7:0] cr_q, tdr_q, rdr_q;
    logic       rdrf_q, tdre_q, ovrn_q, fe_q;

    logic       wr_cr, wr_tdr, rd_data;
    logic [7:0] cr_next;
    logic       mreset, tie, rie, brk, irq;

    assign wr_cr   = ~bus.uart_cs & bus.uart_we & ~bus.uart_rs;
    assign wr_tdr  = ~bus.uart_cs & bus.uart_we & bus.uart_rs;
    assign rd_data = ~bus.uart_cs & bus.uart_rd & bus.uart_rs & ~bus.uart_we;

    // Master reset acts on the edge that writes it, so a mid-frame abort is immediate.
    assign cr_next = wr_cr ? bus.din : cr_q;
    assign mreset  = (cr_next[1:0] == 2'b11);

    assign tie = (cr_q[6:5] == 2'b01);
    assign brk = (cr_q[6:5] == 2'b11);
    assign rie = cr_q[7];
    assign irq = (rie & (rdrf_q | ovrn_q)) | (tie & tdre_q);

    logic unused_cr_bits;
    assign unused_cr_bits = ^cr_q[4:2];

    // ---------------- transmitter ----------------
    tx_state_e   tx_state_q;
    logic [8:0]  tx_shift_q;
    logic [15:0] tx_cnt_q;
    logic [3:0]  tx_bit_q;
    logic        txd_q;
    logic        tx_frame_end, tx_load;

    assign tx_frame_end = (tx_state_q == TxShift) && (tx_cnt_q == '0) && (tx_bit_q == 4'd9);
    // A pending byte reloads straight out of the stop bit, so back-to-back frames have no gap.
    assign tx_load = ~mreset & ~tdre_q & ((tx_state_q == TxIdle) | tx_frame_end);

    always_ff @(posedge cpu_clk) begin
        if (rst || mreset) begin
            tx_state_q <= TxIdle;
            tx_shift_q <= '1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            txd_q      <= 1'b1;
        end else if (tx_load) begin
            tx_state_q <= TxShift;
            tx_shift_q <= {1'b1, tdr_q};
            tx_cnt_q   <= DivM1;
            tx_bit_q   <= '0;
            txd_q      <= 1'b0;
        end else if (tx_state_q == TxShift) begin
            if (tx_cnt_q != '0) begin
                tx_cnt_q <= tx_cnt_q - 16'd1;
            end else if (tx_bit_q == 4'd9) begin
                tx_state_q <= TxIdle;
                txd_q      <= 1'b1;
            end else begin
                txd_q      <= tx_shift_q[0];
                tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                tx_bit_q   <= tx_bit_q + 4'd1;
                tx_cnt_q   <= DivM1;
            end
        end
    end

    assign txd = txd_q & ~brk;

    // ---------------- receiver ----------------
    logic        rxd_meta_q, rxd_sync_q;
    rx_state_e   rx_state_q;
    logic [15:0] rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q;
    logic        rx_stop_q, rx_done_q;

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (rst || mreset) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_stop_q  <= 1'b1;
            rx_done_q  <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            unique case (rx_state_q)
                RxIdle: begin
                    if (!rxd_sync_q) begin
                        rx_state_q <= RxStart;
                        rx_cnt_q   <= DivHalf;
                    end
                end
                RxStart: begin
                    if (rx_cnt_q != '0) begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end else if (!rxd_sync_q) begin
                        rx_state_q <= RxData;
                        rx_cnt_q   <= DivM1;
                        rx_bit_q   <= '0;
                    end else begin
                        rx_state_q <= RxIdle;
                    end
                end
                RxData: begin
                    if (rx_cnt_q != '0) begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end else begin
                        rx_shift_q <= {rxd_sync_q, rx_shift_q[7:1]};
                        rx_cnt_q   <= DivM1;
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
                    end
                end
                RxStop: begin
                    if (rx_cnt_q != '0) begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end else begin
                        rx_stop_q  <= rxd_sync_q;
                        rx_done_q  <= 1'b1;
                        rx_state_q <= RxIdle;
                    end
                end
            endcase
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            cr_q   <= 8'h00;
            tdr_q  <= 8'h00;
            rdr_q  <= 8'h00;
            rdrf_q <= 1'b0;
            tdre_q <= 1'b1;
            ovrn_q <= 1'b0;
            fe_q   <= 1'b0;
        end else begin
            if (wr_cr)  cr_q  <= bus.din;
            if (wr_tdr) tdr_q <= bus.din;
            if (mreset) begin
                rdrf_q <= 1'b0;
                tdre_q <= 1'b1;
                ovrn_q <= 1'b0;
                fe_q   <= 1'b0;
            end else begin
                if (wr_tdr)       tdre_q <= 1'b0;
                else if (tx_load) tdre_q <= 1'b1;
                if (rd_data) begin
                    rdrf_q <= 1'b0;
                    ovrn_q <= 1'b0;
                end
                // A byte landing on the same edge as an RDR read is accepted, not an overrun.
                if (rx_done_q) begin
                    if (rdrf_q && !rd_data) begin
                        ovrn_q <= 1'b1;
                    end else begin
                        rdr_q  <= rx_shift_q;
                        rdrf_q <= 1'b1;
                        fe_q   <= ~rx_stop_q;
                    end
                end
            end
        end
    end

    assign bus.irq_n = ~irq;

    always_comb begin
        bus.dout = 8'h00;
        if (!bus.uart_cs && bus.uart_rd) begin
            bus.dout = bus.uart_rs ? rdr_q
                                   : {irq, 1'b0, ovrn_q, fe_q, 2'b00, tdre_q, rdrf_q};
        end
    end

endmodule

// File: tb/tb_uart_acia.sv
// Scoreboarded bench for uart_acia: bus reads and serial TX frames are checked by
// independent monitors against a behavioural model of the ACIA registers.
module tb_uart_acia;

    localparam int unsigned DIV = 8;

    logic cpu_clk = 1'b0;
    logic rst;
    logic rxd;
    logic txd;

    uart_acia_if bus ();

    uart_acia #(.CLK_DIV(DIV)) dut (
        .cpu_clk(cpu_clk),
        .rst    (rst),
        .bus    (bus),
        .rxd    (rxd),
        .txd    (txd)
    );

    always #5 cpu_clk = ~cpu_clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] rd_q[$];
    logic [9:0] tx_q[$];
    bit         mon_off = 1'b0;

    // Behavioural register model
    logic [7:0] m_cr, m_rdr;
    logic       m_rdrf, m_ovrn, m_fe, m_tdre;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_irq();
        return (m_cr[7] & (m_rdrf | m_ovrn)) | ((m_cr[6:5] == 2'b01) & m_tdre);
    endfunction

    function automatic logic [7:0] m_status();
        return {m_irq(), 1'b0, m_ovrn, m_fe, 2'b00, m_tdre, m_rdrf};
    endfunction

    task automatic model_reset();
        m_cr = 8'h00; m_rdr = 8'h00;
        m_rdrf = 1'b0; m_ovrn = 1'b0; m_fe = 1'b0; m_tdre = 1'b1;
    endtask

    task automatic check_irq(input string name);
        logic e;
        e = !m_irq();
        check(name, 16'(bus.irq_n), 16'(e));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge cpu_clk);
        #1;
    endtask

    task automatic bus_wr(input logic rs, input logic [7:0] d);
        bus.uart_cs = 1'b0; bus.uart_we = 1'b1; bus.uart_rs = rs; bus.din = d;
        tick(1);
        bus.uart_cs = 1'b1; bus.uart_we = 1'b0;
        if (!rs) begin
            m_cr = d;
            if (d[1:0] == 2'b11) begin
                m_rdrf = 1'b0; m_ovrn = 1'b0; m_fe = 1'b0; m_tdre = 1'b1;
            end
        end
    endtask

    task automatic bus_rd(input logic rs, input logic [7:0] exp);
        rd_q.push_back(exp);
        bus.uart_cs = 1'b0; bus.uart_rd = 1'b1; bus.uart_rs = rs;
        tick(1);
        bus.uart_cs = 1'b1; bus.uart_rd = 1'b0;
        if (rs) begin
            m_rdrf = 1'b0; m_ovrn = 1'b0;
        end
    endtask

    task automatic rd_status();
        bus_rd(1'b0, m_status());
    endtask

    task automatic rd_data();
        bus_rd(1'b1, m_rdr);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            tick(DIV);
        end
        rxd = 1'b1;
        tick(DIV);
        if (m_rdrf) m_ovrn = 1'b1;
        else begin
            m_rdr = b; m_rdrf = 1'b1; m_fe = ~stop;
        end
    endtask

    // Read monitor: every strobed read is checked against the queued expectation
    always @(negedge cpu_clk) begin
        if (!bus.uart_cs && bus.uart_rd) begin
            if (rd_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL dout_unexpected: got %h expected no read", bus.dout);
            end else begin
                check("dout", 16'(bus.dout), 16'(rd_q.pop_front()));
            end
        end
    end

    // TX monitor: decodes frames off txd at mid-bit, independent of the stimulus
    initial begin
        logic [9:0] f;
        forever begin
            @(negedge cpu_clk);
            if (!mon_off && txd === 1'b0) begin
                repeat (DIV / 2) @(negedge cpu_clk);
                f[0] = txd;
                for (int i = 1; i < 10; i++) begin
                    repeat (DIV) @(negedge cpu_clk);
                    f[i] = txd;
                end
                if (tx_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL tx_unexpected: got frame %b expected none", f);
                end else begin
                    check("tx_frame", 16'(f), 16'(tx_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b, c, b0, b1, b2;
        logic       stp;

        bus.uart_cs = 1'b1; bus.uart_rd = 1'b0; bus.uart_we = 1'b0;
        bus.uart_rs = 1'b0; bus.din = 8'h00;
        rxd = 1'b1; rst = 1'b1;
        model_reset();
        tick(3);
        rst = 1'b0;

        // Reset state
        check("reset_dout", 16'(bus.dout), 16'h00);
        check("reset_irq_n", 16'(bus.irq_n), 16'h1);
        check("reset_txd", 16'(txd), 16'h1);
        rd_status();

        // TX interrupt and first frame
        bus_wr(1'b0, 8'h20);
        check("tie_irq_n", 16'(bus.irq_n), 16'h0);
        tx_q.push_back({1'b1, 8'hA5, 1'b0});
        bus_wr(1'b1, 8'hA5);
        check("tdre_pending_irq_n", 16'(bus.irq_n), 16'h1);
        tick(1);
        check("tdre_loaded_irq_n", 16'(bus.irq_n), 16'h0);
        tick(10 * DIV + 2);

        // RX basic
        bus_wr(1'b0, 8'h80);
        send_rx(8'h3C, 1'b1);
        check_irq("rx_irq_n");
        rd_status();
        rd_data();
        rd_status();
        check_irq("rx_read_irq_n");

        // Overrun
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        rd_status();
        rd_data();
        rd_status();

        // Framing error, recovery, glitch rejection
        send_rx(8'h55, 1'b0);
        rd_status();
        rd_data();
        send_rx(8'($urandom), 1'b1);
        rd_status();
        rd_data();
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(3 * DIV);
        rd_status();

        // Master reset mid-frame, then a clean frame
        tx_q.push_back({1'b1, 8'hFF, 1'b0});
        bus_wr(1'b1, 8'hFF);
        tick(5 * DIV + DIV / 2 - 1);
        bus_wr(1'b0, 8'h03);
        check("mr_txd", 16'(txd), 16'h1);
        rd_status();
        tick(6 * DIV);
        bus_wr(1'b0, 8'h00);
        tx_q.push_back({1'b1, 8'h81, 1'b0});
        bus_wr(1'b1, 8'h81);
        tick(11 * DIV);

        // Abort a zero byte: line must go high at once and no frame may restart
        mon_off = 1'b1;
        bus_wr(1'b1, 8'h00);
        tick(3 * DIV);
        check("pre_abort_txd", 16'(txd), 16'h0);
        bus_wr(1'b0, 8'h03);
        check("abort_txd", 16'(txd), 16'h1);
        bus_wr(1'b0, 8'h00);
        tick(2 * DIV);
        check("post_abort_txd", 16'(txd), 16'h1);

        // Break forces the line low only while set
        bus_wr(1'b0, 8'h60);
        check("break_txd", 16'(txd), 16'h0);
        bus_wr(1'b0, 8'h00);
        check("unbreak_txd", 16'(txd), 16'h1);

        // Synchronous reset mid-frame
        bus_wr(1'b1, 8'h00);
        tick(2 * DIV);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        model_reset();
        check("rst_txd", 16'(txd), 16'h1);
        rd_status();
        tick(2 * DIV);
        check("rst_idle_txd", 16'(txd), 16'h1);
        mon_off = 1'b0;

        // Pending byte overwritten before it starts
        b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
        tx_q.push_back({1'b1, b0, 1'b0});
        tx_q.push_back({1'b1, b2, 1'b0});
        bus_wr(1'b1, b0);
        bus_wr(1'b1, b1);
        bus_wr(1'b1, b2);
        tick(22 * DIV);

        // Random back-to-back TX
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            tx_q.push_back({1'b1, b, 1'b0});
            bus_wr(1'b1, b);
            if (i == 0) tick(2);
            else        tick(10 * DIV + 4);
        end
        tick(12 * DIV);

        // Random RX with random interrupt enables and optional reads
        for (int i = 0; i < 8; i++) begin
            c = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 5'b00000};
            bus_wr(1'b0, c);
            if ($urandom_range(0, 1) == 1) rd_data();
            b   = 8'($urandom);
            stp = ($urandom_range(0, 3) != 0);
            send_rx(b, stp);
            check_irq("rand_irq_n");
            rd_status();
        end
        rd_data();
        rd_status();

        for (int t = 0; t < 40 * DIV && tx_q.size() != 0; t++) @(posedge cpu_clk);
        tick(2);
        check("tx_drained", 16'(tx_q.size()), 16'h0);
        check("rd_drained", 16'(rd_q.size()), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
